// File: rtl/ex_stage_if.sv
// Decode-to-execute and EX/MEM signal bundle for the execute stage.
// EX_FWD_EN adds the source register numbers and the memory-stage forwarding path.
interface ex_stage_if #(
   parameter int DATA_W = 16
);
   logic              id_valid;
   logic [3:0]        id_opcode;
   logic [DATA_W-1:0] id_src1;
   logic [DATA_W-1:0] id_src2;
   logic [DATA_W-1:0] id_imm;
   logic              id_imm_sel;
   logic [DATA_W-1:0] id_store_data;
   logic [2:0]        id_op_dest;
   logic              id_mem_write_en;
   logic              id_wb_mux;
   logic              id_wb_en;
`ifdef EX_FWD_EN
   logic [2:0]        id_rs1;
   logic [2:0]        id_rs2;
   logic              wb_fwd_en;
   logic [2:0]        wb_fwd_dest;
   logic [DATA_W-1:0] wb_fwd_data;
`endif

   logic              ex_stall;
   logic [3:0]        opcode_ex_mem;
   logic [DATA_W-1:0] ex_alu_res;
   logic [DATA_W-1:0] ex_store_data;
   logic [2:0]        ex_op_dest;
   logic              mem_write_en;
   logic              ex_wb_mux;
   logic              ex_wb_en;

   modport master (
`ifdef EX_FWD_EN
      output id_rs1, id_rs2, wb_fwd_en, wb_fwd_dest, wb_fwd_data,
`endif
      output id_valid, id_opcode, id_src1, id_src2, id_imm, id_imm_sel,
             id_store_data, id_op_dest, id_mem_write_en, id_wb_mux, id_wb_en,
      input  ex_stall, opcode_ex_mem, ex_alu_res, ex_store_data, ex_op_dest,
             mem_write_en, ex_wb_mux, ex_wb_en
   );

   modport slave (
`ifdef EX_FWD_EN
      input  id_rs1, id_rs2, wb_fwd_en, wb_fwd_dest, wb_fwd_data,
`endif
      input  id_valid, id_opcode, id_src1, id_src2, id_imm, id_imm_sel,
             id_store_data, id_op_dest, id_mem_write_en, id_wb_mux, id_wb_en,
      output ex_stall, opcode_ex_mem, ex_alu_res, ex_store_data, ex_op_dest,
             mem_write_en, ex_wb_mux, ex_wb_en
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus a shift-add multiply, registered into EX/MEM.
// Define EX_FWD_EN to forward operands from EX/MEM and the memory-stage writeback.
module ex_stage #(
   parameter int DATA_W     = 16,
   parameter int MUL_CYCLES = 16
) (
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave bus
);
   localparam int               CNT_W    = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam logic [3:0] OP_LW  = 4'd10;
   localparam logic [3:0] OP_SW  = 4'd11;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] mcand, mcand_next, mplier, mplier_next, acc, acc_next, acc_sum;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [2:0]        mul_dest, mul_dest_next;
   logic              mul_wb_en, mul_wb_en_next, mul_wb_mux, mul_wb_mux_next;

   logic [DATA_W-1:0] op_a, op_b, store_val, alu_res;
   logic [3:0]        shamt;
   logic              single_op;
   logic              stall;

   logic [3:0]        opcode_q, opcode_d;
   logic [DATA_W-1:0] res_q, res_d, store_q, store_d;
   logic [2:0]        dest_q, dest_d;
   logic              mwe_q, mwe_d, wbmux_q, wbmux_d, wben_q, wben_d;

   // Operand selection; with forwarding, the EX/MEM result outranks the memory-stage value.
   always_comb begin
      op_a      = bus.id_src1;
      op_b      = bus.id_imm_sel ? bus.id_imm : bus.id_src2;
      store_val = bus.id_store_data;
`ifdef EX_FWD_EN
      if (wben_q && !wbmux_q && dest_q == bus.id_rs1)
         op_a = res_q;
      else if (bus.wb_fwd_en && bus.wb_fwd_dest == bus.id_rs1)
         op_a = bus.wb_fwd_data;
      if (wben_q && !wbmux_q && dest_q == bus.id_rs2) begin
         store_val = res_q;
         if (!bus.id_imm_sel)
            op_b = res_q;
      end else if (bus.wb_fwd_en && bus.wb_fwd_dest == bus.id_rs2) begin
         store_val = bus.wb_fwd_data;
         if (!bus.id_imm_sel)
            op_b = bus.wb_fwd_data;
      end
`endif
   end

   always_comb begin
      shamt     = op_b[3:0];
      alu_res   = '0;
      single_op = 1'b1;
      case (bus.id_opcode)
         OP_ADD, OP_LW, OP_SW: alu_res = op_a + op_b;
         OP_SUB:               alu_res = op_a - op_b;
         OP_AND:               alu_res = op_a & op_b;
         OP_OR:                alu_res = op_a | op_b;
         OP_XOR:               alu_res = op_a ^ op_b;
         OP_SLL:               alu_res = op_a << shamt;
         OP_SRL:               alu_res = op_a >> shamt;
         OP_SRA:               alu_res = $unsigned($signed(op_a) >>> shamt);
         default:              single_op = 1'b0;
      endcase
   end

   // Multiply sequencing and EX/MEM next values; a bubble is the all-zero default.
   always_comb begin
      state_next      = state;
      mcand_next      = mcand;
      mplier_next     = mplier;
      acc_next        = acc;
      cnt_next        = cnt;
      mul_dest_next   = mul_dest;
      mul_wb_en_next  = mul_wb_en;
      mul_wb_mux_next = mul_wb_mux;
      acc_sum         = acc + (mplier[0] ? mcand : '0);
      stall           = 1'b0;
      opcode_d        = '0;
      res_d           = '0;
      store_d         = '0;
      dest_d          = '0;
      mwe_d           = 1'b0;
      wbmux_d         = 1'b0;
      wben_d          = 1'b0;
      case (state)
         IDLE: begin
            if (bus.id_valid) begin
               if (bus.id_opcode == OP_MUL) begin
                  stall           = 1'b1;
                  mcand_next      = op_a;
                  mplier_next     = op_b;
                  acc_next        = '0;
                  cnt_next        = '0;
                  mul_dest_next   = bus.id_op_dest;
                  mul_wb_en_next  = bus.id_wb_en;
                  mul_wb_mux_next = bus.id_wb_mux;
                  state_next      = BUSY;
               end else if (single_op) begin
                  opcode_d = bus.id_opcode;
                  res_d    = alu_res;
                  store_d  = store_val;
                  dest_d   = bus.id_op_dest;
                  mwe_d    = bus.id_mem_write_en;
                  wbmux_d  = bus.id_wb_mux;
                  wben_d   = bus.id_wb_en;
               end
            end
         end
         BUSY: begin
            acc_next    = acc_sum;
            mcand_next  = mcand << 1;
            mplier_next = mplier >> 1;
            cnt_next    = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
               opcode_d   = OP_MUL;
               res_d      = acc_sum;
               dest_d     = mul_dest;
               wbmux_d    = mul_wb_mux;
               wben_d     = mul_wb_en;
               state_next = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand      <= '0;
         mplier     <= '0;
         acc        <= '0;
         cnt        <= '0;
         mul_dest   <= '0;
         mul_wb_en  <= 1'b0;
         mul_wb_mux <= 1'b0;
         opcode_q   <= '0;
         res_q      <= '0;
         store_q    <= '0;
         dest_q     <= '0;
         mwe_q      <= 1'b0;
         wbmux_q    <= 1'b0;
         wben_q     <= 1'b0;
      end else begin
         mcand      <= mcand_next;
         mplier     <= mplier_next;
         acc        <= acc_next;
         cnt        <= cnt_next;
         mul_dest   <= mul_dest_next;
         mul_wb_en  <= mul_wb_en_next;
         mul_wb_mux <= mul_wb_mux_next;
         opcode_q   <= opcode_d;
         res_q      <= res_d;
         store_q    <= store_d;
         dest_q     <= dest_d;
         mwe_q      <= mwe_d;
         wbmux_q    <= wbmux_d;
         wben_q     <= wben_d;
      end
   end

   // Stall is forced low while reset is held so decode is never frozen by a dead multiply.
   assign bus.ex_stall      = stall & ~rst;
   assign bus.opcode_ex_mem = opcode_q;
   assign bus.ex_alu_res    = res_q;
   assign bus.ex_store_data = store_q;
   assign bus.ex_op_dest    = dest_q;
   assign bus.mem_write_en  = mwe_q;
   assign bus.ex_wb_mux     = wbmux_q;
   assign bus.ex_wb_en      = wben_q;
endmodule
